axil_reg_bank: RTL and testbench
================================

// Module: axil_reg_bank
// PURPOSE
// - Parametrised AXI-Lite slave register bank: NS read-only status, NC read/write config and NK shared control words.
// - Successor to the fixed miner register block; sits between the PS AXI-Lite port and miner/hash logic.
// - Accepts AW and W independently, has per-bit hardware clear on control words and per-word config write strobes.
// PARAMETERS
// DW           32   data width; SW = DW/8 strobe bits
// AW           32   AXI address width
// BW           12   decoded address bits (4 kB window); requires NS+NC+NK <= 2**(BW-2)
// NS            2   status word count (>=1)
// NC            2   config word count (>=1)
// NK            1   control word count (>=1)
// CFG_RST       0   [NC*DW] config reset value, word i at bits [i*DW +: DW]
// PORTS
// clk            in   1      clock
// rstn           in   1      synchronous reset, active-low
// status_in      in   NS*DW  status words, sampled at AR handshake
// config_out     out  NC*DW  config registers
// cfg_wr_pulse   out  NC     1-cycle pulse: config word i written by AXI
// ctrl_hw_clr    in   NK*DW  per-bit clear request from logic (level, each cycle)
// ctrl_out       out  NK*DW  control registers
// awvalid/awready/awaddr[AW]  wvalid/wready/wdata[DW]/wstrb[SW]  bvalid/bready/bresp[2]  AXI-Lite write channels
// arvalid/arready/araddr[AW]  rvalid/rready/rdata[DW]/rresp[2]                           AXI-Lite read channels
// BEHAVIOUR
// - Map: word index = addr[BW-1:2]; addr[1:0] and bits >= BW ignored. Index 0..NS-1 status, NS..NS+NC-1 config,
//   NS+NC..NS+NC+NK-1 control, rest unmapped.
// - Reset: bvalid=rvalid=0, rdata=0, bresp=rresp=0, config_out=CFG_RST, ctrl_out=0, cfg_wr_pulse=0; held AW/W dropped.
// - Write path: 1-entry AW holder and 1-entry W holder. awready = !aw_held | fire; wready = !w_held | fire.
//   fire = aw_held & w_held & (!bvalid | bready). On fire: register updated, both holders released, bvalid=1 next cycle.
//   AW+W same cycle N -> fire N+1 -> bvalid and new register value visible N+2. Sustains 1 write/cycle with bready=1.
// - bvalid stays high until bready; a new fire in the bready cycle keeps bvalid high (back-to-back response).
// - Byte strobes: only bytes with wstrb[k]=1 change. wstrb=0 is a legal no-op write that still responds.
// - Config write: word updated, cfg_wr_pulse[i]=1 the following cycle (aligned with new config_out).
// - Control next = (fire&hit ? strobed(cur,wdata) : cur) & ~ctrl_hw_clr. HW clear wins over AXI set on the same bit,
//   same cycle; other bits take AXI data.
// - Status/unmapped writes: no state change.
// - Read path: arready = !rvalid | rready. AR handshake in cycle N -> rdata/rvalid valid N+1, held until rready.
//   1 read/cycle sustained. Read of word written in same cycle returns old value. Unmapped read: rdata=0.
// - Read and write channels independent; no ordering between them.
// - rstn low mid-transaction: outstanding responses abandoned, no B/R issued after reset.
// CONFIGURATION
// - AXIL_REG_BANK_SLVERR_EN defined: write to status/unmapped -> bresp=2'b10; read unmapped -> rresp=2'b10, rdata=0.
// - Not defined: all responses OKAY (2'b00); state behaviour identical.
// TESTING
// - Reset, read all NS+NC+NK words -> status_in values, config=CFG_RST, control=0, rresp=0.
// - AW cycle 3, W cycle 7, bready=1; write 0xA5A5_0001 to idx NS -> bvalid cycle 9, config word0=0xA5A5_0001, pulse cycle 9.
// - Write 0xFFFF_FFFF wstrb=4'b0100 to config word0=0 -> 0x00FF_0000; pulse asserted.
// - Control bit0 AXI write 1 and ctrl_hw_clr[0]=1 same fire cycle -> bit0=0, other written bits set.
// - bready=0 for 5 cycles with 3 AW/W queued -> only 1 accepted beyond held pair; no response lost, 3 B beats in order.
// - Read unmapped idx NS+NC+NK -> rdata=0; rresp=2'b10 with AXIL_REG_BANK_SLVERR_EN, 2'b00 without.

Source files
------------

// File: rtl/axil_reg_bank.sv
// AXI-Lite slave register bank: NS read-only status words, NC read/write
// config words and NK control words with per-bit hardware clear.
// The write path keeps one AW entry and one W entry. It commits a write when
// both entries are held and the B channel can take a new response.
// The read path answers every AR handshake with a response on the next cycle.
// Optional feature macro: AXIL_REG_BANK_SLVERR_EN
//   defined     -> writes to status/unmapped words and reads of unmapped
//                  words answer SLVERR (2'b10)
//   not defined -> every response is OKAY (2'b00)
// The decoded address window is BW bits wide and AW must be larger than BW.
// Register state behaves the same way in both builds.

module axil_reg_bank #(
    parameter int DW = 32,
    parameter int AW = 32,
    parameter int BW = 12,
    parameter int NS = 2,
    parameter int NC = 2,
    parameter int NK = 1,
    parameter logic [NC*DW-1:0] CFG_RST = '0
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NS*DW-1:0]     status_in,
    output logic [NC*DW-1:0]     config_out,
    output logic [NC-1:0]        cfg_wr_pulse,
    input  logic [NK*DW-1:0]     ctrl_hw_clr,
    output logic [NK*DW-1:0]     ctrl_out,
    input  logic                 awvalid,
    output logic                 awready,
    input  logic [AW-1:0]        awaddr,
    input  logic                 wvalid,
    output logic                 wready,
    input  logic [DW-1:0]        wdata,
    input  logic [DW/8-1:0]      wstrb,
    output logic                 bvalid,
    input  logic                 bready,
    output logic [1:0]           bresp,
    input  logic                 arvalid,
    output logic                 arready,
    input  logic [AW-1:0]        araddr,
    output logic                 rvalid,
    input  logic                 rready,
    output logic [DW-1:0]        rdata,
    output logic [1:0]           rresp
);

    localparam int IW = BW - 2;
    localparam int NW = NS + NC + NK;
    localparam int SW = DW / 8;
    localparam logic [1:0] RESP_OKAY = 2'b00;

    // Word indices taken from the live address buses
    logic [IW-1:0]           w_awIdx;
    logic [IW-1:0]           w_arIdx;

    // Held write address and held write data
    logic                    r_awHeld;
    logic [IW-1:0]           r_awIdx;
    logic                    r_wHeld;
    logic [DW-1:0]           r_wData;
    logic [SW-1:0]           r_wStrb;

    // Response channel state
    logic                    r_bvalid;
    logic [1:0]              r_bresp;
    logic                    r_rvalid;
    logic [DW-1:0]           r_rdata;
    logic [1:0]              r_rresp;

    // Register storage
    logic [NC-1:0][DW-1:0]   r_cfg;
    logic [NK-1:0][DW-1:0]   r_ctrl;
    logic [NC-1:0]           r_cfgPulse;

    // Decode and handshake helpers
    logic                    w_fire;
    logic                    w_awHs;
    logic                    w_wHs;
    logic                    w_arHs;
    logic [NC-1:0]           w_wrCfgHit;
    logic [NK-1:0]           w_wrCtrlHit;
    logic [DW-1:0]           w_rdWord;
    logic [1:0]              w_bRespNext;
    logic [1:0]              w_rRespNext;
    logic                    w_unusedAddrBits;

    // Merge new data into a word, changing only the bytes whose strobe is set
    function automatic logic [DW-1:0] strobed(input logic [DW-1:0] cur,
                                              input logic [DW-1:0] data,
                                              input logic [SW-1:0] strb);
        logic [DW-1:0] result;
        result = cur;
        for (int k = 0; k < SW; k++) begin
            if (strb[k]) begin
                result[k*8 +: 8] = data[k*8 +: 8];
            end
        end
        return result;
    endfunction

    assign w_awIdx = awaddr[BW-1:2];
    assign w_arIdx = araddr[BW-1:2];

    // Byte-lane bits and bits above the window have no meaning to the decoder
    assign w_unusedAddrBits = ^{awaddr[AW-1:BW], awaddr[1:0], araddr[AW-1:BW], araddr[1:0]};

    // A write commits once both halves are held and the B slot is free or is being freed
    assign w_fire  = r_awHeld && r_wHeld && (!r_bvalid || bready);
    assign awready = !r_awHeld || w_fire;
    assign wready  = !r_wHeld || w_fire;
    assign arready = !r_rvalid || rready;

    assign w_awHs = awvalid && awready;
    assign w_wHs  = wvalid && wready;
    assign w_arHs = arvalid && arready;

    assign bvalid       = r_bvalid;
    assign bresp        = r_bresp;
    assign rvalid       = r_rvalid;
    assign rdata        = r_rdata;
    assign rresp        = r_rresp;
    assign config_out   = r_cfg;
    assign ctrl_out     = r_ctrl;
    assign cfg_wr_pulse = r_cfgPulse;

`ifdef AXIL_REG_BANK_SLVERR_EN
    // Only config and control words accept writes; only mapped words answer reads
    assign w_bRespNext = (({1'b0, r_awIdx} >= (IW+1)'(NS)) && ({1'b0, r_awIdx} < (IW+1)'(NW)))
                         ? RESP_OKAY : 2'b10;
    assign w_rRespNext = ({1'b0, w_arIdx} < (IW+1)'(NW)) ? RESP_OKAY : 2'b10;
`else
    assign w_bRespNext = RESP_OKAY;
    assign w_rRespNext = RESP_OKAY;
`endif

    // Decode which config or control word the held write address targets
    always_comb begin
        w_wrCfgHit  = '0;
        w_wrCtrlHit = '0;
        for (int i = 0; i < NC; i++) begin
            w_wrCfgHit[i] = (r_awIdx == IW'(NS + i));
        end
        for (int i = 0; i < NK; i++) begin
            w_wrCtrlHit[i] = (r_awIdx == IW'(NS + NC + i));
        end
    end

    // Select the read word; unmapped indices read as zero
    always_comb begin
        w_rdWord = '0;
        for (int i = 0; i < NS; i++) begin
            if (w_arIdx == IW'(i)) begin
                w_rdWord = status_in[i*DW +: DW];
            end
        end
        for (int i = 0; i < NC; i++) begin
            if (w_arIdx == IW'(NS + i)) begin
                w_rdWord = r_cfg[i];
            end
        end
        for (int i = 0; i < NK; i++) begin
            if (w_arIdx == IW'(NS + NC + i)) begin
                w_rdWord = r_ctrl[i];
            end
        end
    end

    // Write address holder: a new address can replace one that commits in the same cycle
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_awHeld <= 1'b0;
            r_awIdx  <= '0;
        end else if (w_awHs) begin
            r_awHeld <= 1'b1;
            r_awIdx  <= w_awIdx;
        end else if (w_fire) begin
            r_awHeld <= 1'b0;
        end
    end

    // Write data holder, which mirrors the address holder
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wHeld <= 1'b0;
            r_wData <= '0;
            r_wStrb <= '0;
        end else if (w_wHs) begin
            r_wHeld <= 1'b1;
            r_wData <= wdata;
            r_wStrb <= wstrb;
        end else if (w_fire) begin
            r_wHeld <= 1'b0;
        end
    end

    // Write response: raised by a commit, held until the master takes it
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_bvalid <= 1'b0;
            r_bresp  <= RESP_OKAY;
        end else if (w_fire) begin
            r_bvalid <= 1'b1;
            r_bresp  <= w_bRespNext;
        end else if (bready) begin
            r_bvalid <= 1'b0;
        end
    end

    // Config words and their one-cycle write pulses, which line up with the new value
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_cfg      <= CFG_RST;
            r_cfgPulse <= '0;
        end else begin
            for (int i = 0; i < NC; i++) begin
                r_cfgPulse[i] <= w_fire && w_wrCfgHit[i];
                if (w_fire && w_wrCfgHit[i]) begin
                    r_cfg[i] <= strobed(r_cfg[i], r_wData, r_wStrb);
                end
            end
        end
    end

    // Control words: the hardware clear is applied after any AXI update, so a clear wins on a bit
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_ctrl <= '0;
        end else begin
            for (int i = 0; i < NK; i++) begin
                if (w_fire && w_wrCtrlHit[i]) begin
                    r_ctrl[i] <= strobed(r_ctrl[i], r_wData, r_wStrb) & ~ctrl_hw_clr[i*DW +: DW];
                end else begin
                    r_ctrl[i] <= r_ctrl[i] & ~ctrl_hw_clr[i*DW +: DW];
                end
            end
        end
    end

    // Read response: captured at the AR handshake and held until the master takes it
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else if (w_arHs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rdWord;
            r_rresp  <= w_rRespNext;
        end else if (rready) begin
            r_rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axil_reg_bank.sv
// Testbench for axil_reg_bank. A behavioural model built from queues and a word
// array predicts every output and is compared with the DUT on each falling edge.
// Directed scenarios also check literal expected values.
// After those, a randomized phase drives all channels.
// The expected error response follows the AXIL_REG_BANK_SLVERR_EN macro.

module tb_axil_reg_bank;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int BW = 12;
    localparam int NS = 2;
    localparam int NC = 2;
    localparam int NK = 1;
    localparam int NW = NS + NC + NK;
    localparam logic [NC*DW-1:0] CFG_RST = {32'hC0DE_0002, 32'hC0DE_0001};
`ifdef AXIL_REG_BANK_SLVERR_EN
    localparam logic [1:0] ERR_RESP = 2'b10;
`else
    localparam logic [1:0] ERR_RESP = 2'b00;
`endif

    logic              clk;
    logic              rstn;
    logic [NS*DW-1:0]  status_in;
    logic [NC*DW-1:0]  config_out;
    logic [NC-1:0]     cfg_wr_pulse;
    logic [NK*DW-1:0]  ctrl_hw_clr;
    logic [NK*DW-1:0]  ctrl_out;
    logic              awvalid;
    logic              awready;
    logic [AW-1:0]     awaddr;
    logic              wvalid;
    logic              wready;
    logic [DW-1:0]     wdata;
    logic [DW/8-1:0]   wstrb;
    logic              bvalid;
    logic              bready;
    logic [1:0]        bresp;
    logic              arvalid;
    logic              arready;
    logic [AW-1:0]     araddr;
    logic              rvalid;
    logic              rready;
    logic [DW-1:0]     rdata;
    logic [1:0]        rresp;

    int checkCount = 0;
    int errorCount = 0;

    axil_reg_bank #(
        .DW(DW), .AW(AW), .BW(BW), .NS(NS), .NC(NC), .NK(NK), .CFG_RST(CFG_RST)
    ) dut (
        .clk(clk), .rstn(rstn),
        .status_in(status_in), .config_out(config_out), .cfg_wr_pulse(cfg_wr_pulse),
        .ctrl_hw_clr(ctrl_hw_clr), .ctrl_out(ctrl_out),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Absolute time limit so the run can never hang
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DW-1:0]   mWord [NW];
    int              awQ [$];
    logic [DW-1:0]   wDataQ [$];
    logic [3:0]      wStrbQ [$];
    logic            mBvalid;
    logic [1:0]      mBresp;
    logic            mRvalid;
    logic [DW-1:0]   mRdata;
    logic [1:0]      mRresp;
    logic [NC-1:0]   mPulse;
    bit              modelLive = 0;

    function automatic logic [DW-1:0] mergeBytes(input logic [DW-1:0] old, input logic [DW-1:0] data,
                                                 input logic [3:0] strb);
        logic [DW-1:0] result;
        result = old;
        for (int k = 0; k < 4; k++) begin
            if (strb[k]) result[k*8 +: 8] = data[k*8 +: 8];
        end
        return result;
    endfunction

    function automatic int addrToIdx(input logic [AW-1:0] a);
        return int'((a % 32'd4096) / 32'd4);
    endfunction

    // Compare the DUT with the model, then advance the model by the coming clock edge
    always @(negedge clk) begin : modelCompare
        logic          fireNow;
        logic          expAw;
        logic          expW;
        logic          expAr;
        logic [NC*DW-1:0] expCfg;
        int            widx;
        int            ridx;
        logic [DW-1:0] d;
        logic [3:0]    s;

        fireNow = (awQ.size() > 0) && (wDataQ.size() > 0) && (!mBvalid || bready);
        expAw   = (awQ.size() == 0) || fireNow;
        expW    = (wDataQ.size() == 0) || fireNow;
        expAr   = !mRvalid || rready;
        for (int i = 0; i < NC; i++) expCfg[i*DW +: DW] = mWord[NS+i];

        if (modelLive) begin
            checkOutput("awready", awready, expAw);
            checkOutput("wready", wready, expW);
            checkOutput("arready", arready, expAr);
            checkOutput("bvalid", bvalid, mBvalid);
            if (mBvalid) checkOutput("bresp", bresp, mBresp);
            checkOutput("rvalid", rvalid, mRvalid);
            if (mRvalid) begin
                checkOutput("rdata", rdata, mRdata);
                checkOutput("rresp", rresp, mRresp);
            end
            checkOutput("config_out", config_out, expCfg);
            checkOutput("ctrl_out", ctrl_out, mWord[NS+NC]);
            checkOutput("cfg_wr_pulse", cfg_wr_pulse, mPulse);
        end

        if (!rstn) begin
            for (int i = 0; i < NW; i++) mWord[i] = '0;
            for (int i = 0; i < NC; i++) mWord[NS+i] = CFG_RST[i*DW +: DW];
            awQ.delete();
            wDataQ.delete();
            wStrbQ.delete();
            mBvalid = 0;
            mBresp  = 2'b00;
            mRvalid = 0;
            mRdata  = '0;
            mRresp  = 2'b00;
            mPulse  = '0;
            modelLive = 1;
        end else if (modelLive) begin
            // reads see the contents from before this edge's write
            if (arvalid && expAr) begin
                ridx = addrToIdx(araddr);
                mRvalid = 1;
                mRresp  = 2'b00;
                if (ridx < NS) mRdata = status_in[ridx*DW +: DW];
                else if (ridx < NW) mRdata = mWord[ridx];
                else begin
                    mRdata = '0;
                    mRresp = ERR_RESP;
                end
            end else if (rready) begin
                mRvalid = 0;
            end
            mPulse = '0;
            if (fireNow) begin
                widx = awQ.pop_front();
                d = wDataQ.pop_front();
                s = wStrbQ.pop_front();
                if (widx >= NS && widx < NW) begin
                    mWord[widx] = mergeBytes(mWord[widx], d, s);
                    mBresp = 2'b00;
                end else begin
                    mBresp = ERR_RESP;
                end
                if (widx >= NS && widx < NS + NC) mPulse[widx-NS] = 1'b1;
                mBvalid = 1;
            end else if (bready) begin
                mBvalid = 0;
            end
            for (int k = 0; k < NK; k++) mWord[NS+NC+k] = mWord[NS+NC+k] & ~ctrl_hw_clr[k*DW +: DW];
            if (awvalid && expAw) awQ.push_back(addrToIdx(awaddr));
            if (wvalid && expW) begin
                wDataQ.push_back(wdata);
                wStrbQ.push_back(wstrb);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    bit awHs;
    bit wHs;
    bit arHs;
    bit stopNew = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] randomAddr();
        logic [AW-1:0] idx;
        idx = AW'($urandom_range(0, NW + 1));
        return ($urandom & 32'hFFFF_F003) | (idx << 2);
    endfunction

    // Present one AW and one W together and return once both are accepted
    task automatic doWrite(input int idx, input logic [31:0] data, input logic [3:0] strb);
        bit awDone;
        bit wDone;
        int guard;
        awDone = 0;
        wDone = 0;
        guard = 0;
        awvalid = 1;
        awaddr = AW'(idx) << 2;
        wvalid = 1;
        wdata = data;
        wstrb = strb;
        while (!(awDone && wDone) && guard < 50) begin
            @(negedge clk);
            if (awvalid && awready) awDone = 1;
            if (wvalid && wready) wDone = 1;
            tick();
            if (awDone) awvalid = 0;
            if (wDone) wvalid = 0;
            guard++;
        end
        if (!(awDone && wDone)) checkOutput("writeAcceptTimeout", 0, 1);
        awvalid = 0;
        wvalid = 0;
    endtask

    // Wait for the write response; bready is expected to be high
    task automatic waitB(output logic [NC-1:0] pulseSeen, output logic [1:0] respSeen);
        bit found;
        int guard;
        found = 0;
        guard = 0;
        pulseSeen = '0;
        respSeen = '0;
        while (!found && guard < 50) begin
            @(negedge clk);
            guard++;
            if (bvalid) begin
                found = 1;
                pulseSeen = cfg_wr_pulse;
                respSeen = bresp;
            end
        end
        if (!found) checkOutput("bResponseTimeout", 0, 1);
        tick();
    endtask

    // Issue one read and collect its data; rready is expected to be high
    task automatic readWord(input int idx, output logic [DW-1:0] data, output logic [1:0] resp);
        bit done;
        int guard;
        done = 0;
        guard = 0;
        data = '0;
        resp = '0;
        arvalid = 1;
        araddr = AW'(idx) << 2;
        while (!done && guard < 50) begin
            @(negedge clk);
            if (arready) done = 1;
            tick();
            guard++;
        end
        arvalid = 0;
        if (!done) checkOutput("arAcceptTimeout", 0, 1);
        done = 0;
        guard = 0;
        while (!done && guard < 50) begin
            @(negedge clk);
            guard++;
            if (rvalid) begin
                done = 1;
                data = rdata;
                resp = rresp;
            end
        end
        if (!done) checkOutput("rResponseTimeout", 0, 1);
        tick();
    endtask

    // Random per-cycle stimulus that holds each valid until its handshake completes
    task automatic applyStimulus();
        if (!awvalid || awHs) begin
            awvalid = !stopNew && ($urandom_range(0, 2) != 0);
            awaddr = randomAddr();
        end
        if (!wvalid || wHs) begin
            wvalid = !stopNew && ($urandom_range(0, 2) != 0);
            wdata = $urandom;
            wstrb = 4'($urandom_range(0, 15));
        end
        if (!arvalid || arHs) begin
            arvalid = !stopNew && ($urandom_range(0, 2) != 0);
            araddr = randomAddr();
        end
        bready = stopNew || ($urandom_range(0, 3) != 0);
        rready = stopNew || ($urandom_range(0, 3) != 0);
        ctrl_hw_clr = ($urandom_range(0, 4) == 0 && !stopNew) ? ($urandom & $urandom) : '0;
        if ($urandom_range(0, 7) == 0) status_in = {$urandom, $urandom};
    endtask

    // ---------------- directed scenarios then random traffic ----------------
    initial begin : mainSeq
        logic [DW-1:0]    rd;
        logic [1:0]       rr;
        logic [NC-1:0]    pulse;
        logic [1:0]       br;
        logic [DW-1:0]    expReset [NW];
        logic [DW-1:0]    bpVals [3];
        int               awI;
        int               wI;
        int               bBeats;
        int               acceptedDuring;
        int               cyc;

        rstn = 0;
        status_in = {32'h2222_0001, 32'h1111_0000};
        ctrl_hw_clr = '0;
        awvalid = 0; awaddr = '0;
        wvalid = 0; wdata = '0; wstrb = '0;
        arvalid = 0; araddr = '0;
        bready = 1;
        rready = 1;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1;

        // reset state
        @(negedge clk);
        checkOutput("rst_bvalid", bvalid, 1'b0);
        checkOutput("rst_rvalid", rvalid, 1'b0);
        checkOutput("rst_rdata", rdata, 32'h0);
        checkOutput("rst_config", config_out, 64'hC0DE_0002_C0DE_0001);
        checkOutput("rst_ctrl", ctrl_out, 32'h0);
        checkOutput("rst_pulse", cfg_wr_pulse, 2'b00);
        tick();

        expReset = '{32'h1111_0000, 32'h2222_0001, 32'hC0DE_0001, 32'hC0DE_0002, 32'h0};
        for (int i = 0; i < NW; i++) begin
            readWord(i, rd, rr);
            checkOutput($sformatf("rst_read%0d", i), rd, expReset[i]);
            checkOutput($sformatf("rst_rresp%0d", i), rr, 2'b00);
        end

        // AW first, W four cycles later: response two cycles after W
        awvalid = 1;
        awaddr = AW'(NS) << 2;
        @(negedge clk);
        checkOutput("awreadyIdle", awready, 1'b1);
        tick();
        awvalid = 0;
        repeat (3) tick();
        wvalid = 1;
        wdata = 32'hA5A5_0001;
        wstrb = 4'hF;
        @(negedge clk);
        checkOutput("wreadyIdle", wready, 1'b1);
        tick();
        wvalid = 0;
        @(negedge clk);
        checkOutput("bvalidNotYet", bvalid, 1'b0);
        @(negedge clk);
        checkOutput("bvalidAligned", bvalid, 1'b1);
        checkOutput("pulseAligned", cfg_wr_pulse, 2'b01);
        checkOutput("cfg0Written", config_out[31:0], 32'hA5A5_0001);
        tick();

        // byte strobe on a cleared config word
        doWrite(NS, 32'h0, 4'hF);
        waitB(pulse, br);
        doWrite(NS, 32'hFFFF_FFFF, 4'b0100);
        waitB(pulse, br);
        checkOutput("strobePulse", pulse, 2'b01);
        checkOutput("strobeBresp", br, 2'b00);
        readWord(NS, rd, rr);
        checkOutput("strobeRead", rd, 32'h00FF_0000);

        // hardware clear on bit0 overrides the AXI write of bit0
        ctrl_hw_clr = 32'h1;
        doWrite(NS + NC, 32'h0000_00FF, 4'hF);
        waitB(pulse, br);
        ctrl_hw_clr = '0;
        @(negedge clk);
        checkOutput("ctrlClrWins", ctrl_out, 32'h0000_00FE);
        tick();
        ctrl_hw_clr = 32'h0000_00F0;
        tick();
        ctrl_hw_clr = '0;
        @(negedge clk);
        checkOutput("ctrlHwClear", ctrl_out, 32'h0000_000E);
        tick();

        // response backpressure: three writes queued while bready is low for five cycles
        bpVals = '{32'h11, 32'h22, 32'h33};
        awI = 0;
        wI = 0;
        bBeats = 0;
        acceptedDuring = 0;
        cyc = 0;
        while (bBeats < 3 && cyc < 40) begin
            awvalid = (awI < 3);
            awaddr = AW'(NS + 1) << 2;
            wvalid = (wI < 3);
            wdata = bpVals[(wI < 3) ? wI : 2];
            wstrb = 4'hF;
            bready = (cyc >= 5);
            @(negedge clk);
            if (awvalid && awready) awI++;
            if (wvalid && wready) wI++;
            if (bvalid && bready) bBeats++;
            if (cyc == 4) acceptedDuring = awI;
            tick();
            cyc++;
        end
        awvalid = 0;
        wvalid = 0;
        bready = 1;
        checkOutput("bpAccepted", acceptedDuring, 2);
        checkOutput("bpBeats", bBeats, 3);
        @(negedge clk);
        checkOutput("bpFinalCfg1", config_out[63:32], 32'h33);
        tick();

        // unmapped accesses
        readWord(NW, rd, rr);
        checkOutput("unmappedRdata", rd, 32'h0);
        checkOutput("unmappedRresp", rr, ERR_RESP);
        doWrite(NW + 1, 32'hDEAD_BEEF, 4'hF);
        waitB(pulse, br);
        checkOutput("unmappedBresp", br, ERR_RESP);
        checkOutput("unmappedPulse", pulse, 2'b00);
        doWrite(0, 32'hDEAD_BEEF, 4'hF);
        waitB(pulse, br);
        checkOutput("statusWriteBresp", br, ERR_RESP);

        // reset while a write and a read are outstanding
        awvalid = 1; awaddr = AW'(NS) << 2;
        wvalid = 1; wdata = 32'h1234_5678; wstrb = 4'hF;
        arvalid = 1; araddr = AW'(NS) << 2;
        tick();
        awvalid = 0; wvalid = 0; arvalid = 0;
        rstn = 0;
        repeat (2) tick();
        rstn = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("postRstBvalid", bvalid, 1'b0);
            checkOutput("postRstRvalid", rvalid, 1'b0);
            tick();
        end
        @(negedge clk);
        checkOutput("postRstConfig", config_out, 64'hC0DE_0002_C0DE_0001);
        tick();

        // randomized traffic on all channels
        awHs = 0; wHs = 0; arHs = 0;
        for (int n = 0; n < 3000; n++) begin
            if (n == 2950) stopNew = 1;
            applyStimulus();
            @(negedge clk);
            awHs = awvalid && awready;
            wHs = wvalid && wready;
            arHs = arvalid && arready;
            tick();
        end
        awvalid = 0; wvalid = 0; arvalid = 0;
        bready = 1; rready = 1;
        repeat (10) tick();

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
